// File: rtl/shared_mem_responder.sv
// ============================================================================
// Module   : shared_mem_responder
// Brief    : Two-port round-robin responder in front of one shared memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shared_mem_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter int WORD_WIDTH = 16,
  parameter int RW_WIDTH   = 2,
  parameter int DEPTH      = 256,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [RW_WIDTH-1:0]   rwFromCacheA,
  input  logic [ADDR_WIDTH-1:0] addrFromCacheA,
  input  logic [WORD_WIDTH-1:0] dataFromCacheA,
  output logic [WORD_WIDTH-1:0] dataToCacheA,
  output logic                  rdEnToCacheA,
  output logic                  wbDoneToCacheA,
  input  logic [RW_WIDTH-1:0]   rwFromCacheB,
  input  logic [ADDR_WIDTH-1:0] addrFromCacheB,
  input  logic [WORD_WIDTH-1:0] dataFromCacheB,
  output logic [WORD_WIDTH-1:0] dataToCacheB,
  output logic                  rdEnToCacheB,
  output logic                  wbDoneToCacheB
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [RW_WIDTH-1:0] RW_READ  = RW_WIDTH'(1);
  localparam logic [RW_WIDTH-1:0] RW_WRITE = RW_WIDTH'(2);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  state_t                state_q, state_d;
  logic                  rr_q, rr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  mask_a_q, mask_a_d;
  logic                  mask_b_q, mask_b_d;
  logic                  port_q, port_d;
  logic                  is_wr_q, is_wr_d;
  logic [IDX_W-1:0]      addr_q, addr_d;
  logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
  logic [WORD_WIDTH-1:0] data_a_q, data_a_d;
  logic [WORD_WIDTH-1:0] data_b_q, data_b_d;
  logic                  rd_a_q, rd_a_d;
  logic                  wb_a_q, wb_a_d;
  logic                  rd_b_q, rd_b_d;
  logic                  wb_b_q, wb_b_d;

  logic                  elig_a, elig_b;
  logic                  grant_a, grant_b;
  logic [RW_WIDTH-1:0]   sel_rw;
  logic                  mem_we;

  generate
    if (ADDR_WIDTH > IDX_W) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^{addrFromCacheA[ADDR_WIDTH-1:IDX_W],
                                addrFromCacheB[ADDR_WIDTH-1:IDX_W]};
    end
  endgenerate

  // A port just served is masked for one IDLE cycle so its cache can retire rw.
  assign elig_a  = ((rwFromCacheA == RW_READ) || (rwFromCacheA == RW_WRITE)) && !mask_a_q;
  assign elig_b  = ((rwFromCacheB == RW_READ) || (rwFromCacheB == RW_WRITE)) && !mask_b_q;
  assign grant_a = elig_a && (!elig_b || !rr_q);
  assign grant_b = elig_b && !grant_a;
  assign sel_rw  = grant_b ? rwFromCacheB : rwFromCacheA;
  assign mem_we  = (state_q == S_ACCESS) && (cnt_q == '0) && is_wr_q;

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    mask_a_d = mask_a_q;
    mask_b_d = mask_b_q;
    port_d   = port_q;
    is_wr_d  = is_wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    rd_a_d   = 1'b0;
    wb_a_d   = 1'b0;
    rd_b_d   = 1'b0;
    wb_b_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        mask_a_d = 1'b0;
        mask_b_d = 1'b0;
        if (grant_a || grant_b) begin
          port_d  = grant_b;
          is_wr_d = (sel_rw == RW_WRITE);
          addr_d  = grant_b ? addrFromCacheB[IDX_W-1:0] : addrFromCacheA[IDX_W-1:0];
          wdata_d = grant_b ? dataFromCacheB : dataFromCacheA;
          cnt_d   = CNT_W'(LATENCY - 1);
          rr_d    = !grant_b;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = S_RESPOND;
          if (is_wr_q) begin
            wb_a_d = !port_q;
            wb_b_d = port_q;
          end else if (port_q) begin
            rd_b_d   = 1'b1;
            data_b_d = mem[addr_q];
          end else begin
            rd_a_d   = 1'b1;
            data_a_d = mem[addr_q];
          end
        end
      end
      S_RESPOND: begin
        state_d = S_IDLE;
        if (port_q) mask_b_d = 1'b1;
        else        mask_a_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      rr_q     <= 1'b0;
      cnt_q    <= '0;
      mask_a_q <= 1'b0;
      mask_b_q <= 1'b0;
      port_q   <= 1'b0;
      is_wr_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      data_a_q <= '0;
      data_b_q <= '0;
      rd_a_q   <= 1'b0;
      wb_a_q   <= 1'b0;
      rd_b_q   <= 1'b0;
      wb_b_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      mask_a_q <= mask_a_d;
      mask_b_q <= mask_b_d;
      port_q   <= port_d;
      is_wr_q  <= is_wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      rd_a_q   <= rd_a_d;
      wb_a_q   <= wb_a_d;
      rd_b_q   <= rd_b_d;
      wb_b_q   <= wb_b_d;
    end
  end

  // Contents survive reset; a write whose commit edge sees reset is dropped.
  always_ff @(posedge clk) begin
    if (reset && mem_we) begin
      mem[addr_q] <= wdata_q;
    end
  end

  assign dataToCacheA   = data_a_q;
  assign rdEnToCacheA   = rd_a_q;
  assign wbDoneToCacheA = wb_a_q;
  assign dataToCacheB   = data_b_q;
  assign rdEnToCacheB   = rd_b_q;
  assign wbDoneToCacheB = wb_b_q;

endmodule

`default_nettype wire

// File: tb/tb_shared_mem_responder.sv
// ============================================================================
// Module   : tb_shared_mem_responder
// Brief    : Randomized bench against a cycle-arithmetic transaction model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shared_mem_responder;

  localparam int AW    = 16;
  localparam int WW    = 16;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    rw_a, rw_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [WW-1:0] wd_a, wd_b;
  logic [WW-1:0] dataToCacheA, dataToCacheB;
  logic          rdEnToCacheA, wbDoneToCacheA, rdEnToCacheB, wbDoneToCacheB;

  always #5 clk = ~clk;

  shared_mem_responder #(
    .ADDR_WIDTH(AW), .WORD_WIDTH(WW), .RW_WIDTH(2), .DEPTH(DEPTH), .LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .rwFromCacheA(rw_a), .addrFromCacheA(addr_a), .dataFromCacheA(wd_a),
    .dataToCacheA(dataToCacheA), .rdEnToCacheA(rdEnToCacheA), .wbDoneToCacheA(wbDoneToCacheA),
    .rwFromCacheB(rw_b), .addrFromCacheB(addr_b), .dataFromCacheB(wd_b),
    .dataToCacheB(dataToCacheB), .rdEnToCacheB(rdEnToCacheB), .wbDoneToCacheB(wbDoneToCacheB)
  );

  int      n_cmp = 0;
  int      n_mis = 0;
  longint  cyc   = 0;

  // Reference model: memory image plus one in-flight transaction keyed by cycle numbers.
  logic [WW-1:0] mem_m [DEPTH];
  bit            pend;
  longint        pend_cyc;
  int            pend_port;
  bit            pend_wr;
  int            pend_idx;
  logic [WW-1:0] pend_data;
  longint        next_free;
  longint        mask_cyc;
  int            mask_port;
  int            rr;
  logic [WW-1:0] exp_da, exp_db;
  logic [3:0]    exp_p;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit valid_rw(input logic [1:0] rw);
    return (rw == 2'b01) || (rw == 2'b10);
  endfunction

  task automatic model_edge();
    bit ea, eb;
    int g;
    exp_p = 4'b0000;
    if (!reset) begin
      pend      = 1'b0;
      rr        = 0;
      next_free = cyc + 1;
      mask_cyc  = -1;
      exp_da    = '0;
      exp_db    = '0;
      return;
    end
    if (pend && cyc == pend_cyc) begin
      pend = 1'b0;
      if (pend_wr) begin
        mem_m[pend_idx] = pend_data;
        exp_p = (pend_port == 0) ? 4'b0100 : 4'b0001;
      end else if (pend_port == 0) begin
        exp_da = mem_m[pend_idx];
        exp_p  = 4'b1000;
      end else begin
        exp_db = mem_m[pend_idx];
        exp_p  = 4'b0010;
      end
    end
    if (cyc >= next_free) begin
      ea = valid_rw(rw_a) && !(mask_port == 0 && cyc == mask_cyc);
      eb = valid_rw(rw_b) && !(mask_port == 1 && cyc == mask_cyc);
      g  = -1;
      if (ea && (!eb || rr == 0)) g = 0;
      else if (eb)                g = 1;
      if (g >= 0) begin
        pend      = 1'b1;
        pend_cyc  = cyc + LAT;
        pend_port = g;
        pend_wr   = ((g == 0) ? rw_a : rw_b) == 2'b10;
        pend_idx  = int'((g == 0) ? addr_a : addr_b) % DEPTH;
        pend_data = (g == 0) ? wd_a : wd_b;
        next_free = cyc + LAT + 2;
        mask_port = g;
        mask_cyc  = next_free;
        rr        = 1 - g;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check("pulses", {28'd0, rdEnToCacheA, wbDoneToCacheA, rdEnToCacheB, wbDoneToCacheB}, {28'd0, exp_p});
    check("dataA", {16'd0, dataToCacheA}, {16'd0, exp_da});
    check("dataB", {16'd0, dataToCacheB}, {16'd0, exp_db});
  endtask

  // Hold the requested ports until each sees its pulse, plus 'extra' more cycles.
  task automatic serve(input bit wa, input bit wb, input int extra);
    bit da, db;
    int k;
    da = !wa;
    db = !wb;
    k  = 0;
    while (!(da && db) && k < 40) begin
      tick();
      k++;
      if (!da && (rdEnToCacheA || wbDoneToCacheA)) begin
        da = 1'b1;
        if (extra == 0) rw_a = 2'b00;
      end
      if (!db && (rdEnToCacheB || wbDoneToCacheB)) begin
        db = 1'b1;
        if (extra == 0) rw_b = 2'b00;
      end
    end
    if (!(da && db)) check("serve_timeout", 32'd0, 32'd1);
    for (int i = 0; i < extra; i++) tick();
    rw_a = 2'b00;
    rw_b = 2'b00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset  = 1'b0;
    rw_a   = 2'b00; rw_b = 2'b00;
    addr_a = '0;    addr_b = '0;
    wd_a   = '0;    wd_b   = '0;
    pend = 1'b0; rr = 0; next_free = 0; mask_cyc = -1; mask_port = 0;
    exp_da = '0; exp_db = '0;

    idle(3);
    reset = 1'b1;
    idle(2);

    // Preload the whole array through port A so every later read is predictable.
    for (int a = 0; a < DEPTH; a++) begin
      rw_a = 2'b10; addr_a = AW'(a); wd_a = WW'($urandom);
      serve(1'b1, 1'b0, 0);
    end

    // Single write then read on A.
    rw_a = 2'b10; addr_a = 16'h0000; wd_a = 16'h0003;
    serve(1'b1, 1'b0, 0);
    rw_a = 2'b01;
    serve(1'b1, 1'b0, 0);
    idle(3);
    check("t1_hold", {16'd0, dataToCacheA}, 32'h0003);

    // Simultaneous requests right after reset: A writes first, B reads it back.
    reset = 1'b0; idle(2); reset = 1'b1;
    rw_a = 2'b10; addr_a = 16'h0005; wd_a = 16'h1111;
    rw_b = 2'b01; addr_b = 16'h0005;
    serve(1'b1, 1'b1, 0);
    idle(2);
    check("t2_readback", {16'd0, dataToCacheB}, 32'h1111);

    // Both ports hold reads continuously.
    rw_a = 2'b01; addr_a = 16'h0001;
    rw_b = 2'b01; addr_b = 16'h0002;
    idle(24);
    rw_a = 2'b00; rw_b = 2'b00;
    idle(6);

    // Turnaround mask: A lingers on rw=read after its pulse.
    rw_a = 2'b01; addr_a = 16'h0009;
    serve(1'b1, 1'b0, 3);
    idle(6);

    // Reset one cycle after the grant aborts the write.
    rw_a = 2'b10; addr_a = 16'h0007; wd_a = 16'h0000;
    serve(1'b1, 1'b0, 0);
    idle(2);
    rw_a = 2'b10; addr_a = 16'h0007; wd_a = 16'hBEEF;
    tick();
    tick();
    reset = 1'b0; rw_a = 2'b00;
    tick();
    check("t5_rst_dataA", {16'd0, dataToCacheA}, 32'h0);
    tick();
    reset = 1'b1;
    rw_b = 2'b01; addr_b = 16'h0007;
    serve(1'b0, 1'b1, 0);
    idle(1);
    check("t5_addr7", {16'd0, dataToCacheB}, 32'h0000);

    // Aliasing and the invalid code.
    rw_a = 2'b10; addr_a = 16'h0103; wd_a = 16'h00AA;
    serve(1'b1, 1'b0, 0);
    rw_b = 2'b01; addr_b = 16'h0003;
    serve(1'b0, 1'b1, 0);
    idle(1);
    check("t6_alias", {16'd0, dataToCacheB}, 32'h00AA);
    rw_a = 2'b11; rw_b = 2'b11;
    idle(10);
    rw_a = 2'b00; rw_b = 2'b00;
    idle(4);

    // Random traffic: inputs may change at any time, occasional resets.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 249) != 0);
      if ($urandom_range(0, 3) == 0) begin
        rw_a   = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        addr_a = {8'($urandom), 5'd0, 3'($urandom)};
        wd_a   = WW'($urandom);
      end
      if ($urandom_range(0, 3) == 0) begin
        rw_b   = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        addr_b = {8'($urandom), 5'd0, 3'($urandom)};
        wd_b   = WW'($urandom);
      end
      tick();
    end
    reset = 1'b1;
    rw_a = 2'b00; rw_b = 2'b00;
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shared_mem_responder.md
Name: shared_mem_responder

Overview:
- Memory-side responder for the cache-to-memory request interface. Each cache holds `rw`/`addr`/`data` until it receives a one-cycle `rdEn` or `wbDone` pulse.
- Serves two cache ports (A, B) against one shared word-addressed memory array.
- Arbitrates between A and B round-robin, applies a fixed access latency, and returns read data or write-done pulses.
- Sits between the two L1 caches and the backing store in the dual-processor testbench.

Parameters:
- ADDR_WIDTH, 16, request address width; only the low log2(DEPTH) bits index memory.
- WORD_WIDTH, 16, data word width.
- RW_WIDTH, 2, request code width: 2'b00 idle, 2'b01 read, 2'b10 write, 2'b11 treated as idle.
- DEPTH, 256, number of memory words (power of two).
- LATENCY, 2, cycles from grant to response (≥1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- rwFromCacheA  in  RW_WIDTH  port A request code, held until its done pulse.
- addrFromCacheA  in  ADDR_WIDTH  port A address.
- dataFromCacheA  in  WORD_WIDTH  port A write data.
- dataToCacheA  out  WORD_WIDTH  port A read data.
- rdEnToCacheA  out  1  port A read-done pulse.
- wbDoneToCacheA  out  1  port A write-done pulse.
- rwFromCacheB, addrFromCacheB, dataFromCacheB, dataToCacheB, rdEnToCacheB, wbDoneToCacheB: same as port A, for port B.

Behaviour:
- Reset (reset==0 at an edge):
  - State goes to IDLE; round-robin pointer points to A; latency counter = 0; masks cleared.
  - All pulses = 0; dataToCacheA/B = 0.
  - Memory contents are not cleared.
- Reset mid-operation: the in-flight access is aborted. No pulse is issued, and a pending write is not committed if its commit edge has not yet occurred.
- FSM has three states: IDLE, ACCESS, RESPOND.
- IDLE:
  - A port is eligible if its rw is read or write and it is not masked.
  - If neither port is eligible, stay in IDLE.
  - If exactly one is eligible, grant it. If both are eligible, grant the port named by the pointer.
  - On grant: latch port id, rw, addr[log2(DEPTH)-1:0] and write data; counter = LATENCY-1; go to ACCESS; pointer moves to the non-granted port.
- ACCESS:
  - If counter != 0, decrement it.
  - If counter == 0, commit the access:
    - write: mem[addr] <= data; set the granted port's wbDone = 1.
    - read: granted port's dataToCache <= mem[addr]; set its rdEn = 1.
  - After commit, go to RESPOND.
- RESPOND (one cycle):
  - At its ending edge, clear the pulse, set the mask for the served port for the next IDLE cycle only, and go to IDLE.
  - The mask lets the cache drop or replace rw after seeing the pulse.
- Timing:
  - Pulses are registered and last exactly one cycle.
  - The pulse is high in the cycle following edge k+LATENCY, where k is the grant edge.
  - Minimum spacing between two grants is LATENCY+2 cycles.
- Read data is valid with rdEn and is held until that port's next read completes. The other port's data output is unaffected.
- Only one pulse can be high at any time.
- Ordering:
  - Accesses are serialized in grant order.
  - A read granted after a write to the same address returns the written value.
- A port whose rw changes while it is not granted is sampled fresh at its next grant. The latched request is immune to input changes after grant.
- Address bits above log2(DEPTH) are ignored (aliasing wraps).

Test Plan:
1. Single write then read:
   - A writes 0x0003 to addr 0, LATENCY=2, with the grant taken at edge k.
   - Required: wbDoneToCacheA high for exactly one cycle after edge k+2.
   - Then A reads addr 0. Required: rdEnToCacheA pulses one cycle with dataToCacheA = 0x0003, which stays 0x0003 afterwards.
2. Simultaneous requests after reset:
   - A writes 0x1111 to addr 5 while B reads addr 5, both held from the same cycle.
   - Required: A is served first; B gets rdEn with data 0x1111; no cycle has both pulses high.
3. Round-robin fairness:
   - A and B continuously hold reads to addrs 1 and 2.
   - Required: grants alternate A, B, A, B; consecutive pulses are spaced LATENCY+2 cycles apart.
4. Turnaround mask:
   - A keeps rw=read held one extra cycle after its rdEn, and B is idle.
   - Required: A is not re-granted in the cycle immediately after RESPOND; it is re-granted one cycle later.
5. Reset mid-access:
   - A writes 0xBEEF to addr 7; reset goes low one cycle after the grant; then B reads addr 7.
   - Required: no wbDone pulse; addr 7 keeps its prior value (0x0000 when preloaded); all outputs are 0 during reset.
6. Address aliasing and invalid code:
   - A writes 0x00AA to addr 0x0103 (DEPTH=256), then B reads addr 0x0003. Required: B gets 0x00AA.
   - rw=2'b11 on either port. Required: treated as idle; no pulse.
